// File: rtl/sprite_frame_scheduler.sv
// Frame-synchronous sprite position scheduler between physics units and VGA_driver.
// Updates land in shadow registers via round-robin arbitration and commit at frame end.
`timescale 1ns/1ps

module sprite_frame_scheduler #(
  parameter int SPRITES = 4,
  parameter int ROW_MAX = 1249,
  parameter int COL_MAX = 2159
) (
  input  logic                      clock_162,
  input  logic                      rst,
  input  logic [10:0]               row,
  input  logic [11:0]               col,
  input  logic [SPRITES-1:0]        req_valid,
  input  logic [SPRITES-1:0][10:0]  req_row,
  input  logic [SPRITES-1:0][11:0]  req_col,
  output logic [SPRITES-1:0]        req_ready,
  output logic [SPRITES-1:0][10:0]  sprite_row,
  output logic [SPRITES-1:0][11:0]  sprite_col,
  output logic                      frame_tick,
  output logic [SPRITES-1:0]        missed,
  output logic [15:0]               frame_count
);

  localparam int PW = (SPRITES > 1) ? $clog2(SPRITES) : 1;
  localparam logic [PW:0] S_W = (PW+1)'(SPRITES);
  localparam logic [PW-1:0] LAST = PW'(SPRITES - 1);

  typedef enum logic {
    ACCEPT,
    COMMIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                     boundary;
  logic                     arb_en;
  logic [SPRITES-1:0]       pending;
  logic [SPRITES-1:0]       eligible;
  logic [2*SPRITES-1:0]     doubled;
  logic [SPRITES-1:0]       rot;
  logic [SPRITES-1:0]       grant_oh;
  logic                     grant_any;
  logic [PW-1:0]            grant_off;
  logic [PW:0]              grant_sum;
  logic [PW-1:0]            grant_idx;
  logic [PW-1:0]            rr_ptr;
  logic [PW-1:0]            rr_nxt;
  logic                     xfer;
  logic [SPRITES-1:0][10:0] shadow_row;
  logic [SPRITES-1:0][11:0] shadow_col;

  assign boundary = (row == 11'(ROW_MAX)) &&
                    (col == 12'(COL_MAX));

  always_ff @(posedge clock_162) begin
    if (rst) begin
      state <= ACCEPT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    case (state)
      ACCEPT: begin
        arb_en = !boundary && !rst;
        if (boundary) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        state_nxt = ACCEPT;
      end
    endcase
  end

  // Rotate so rr_ptr sits at bit 0, then take the lowest set bit.
  assign eligible = req_valid & ~pending;
  assign doubled  = {eligible, eligible};
  assign rot      = SPRITES'(doubled >> rr_ptr);

  always_comb begin
    grant_any = 1'b0;
    grant_off = '0;
    for (int k = 0; k < SPRITES; k++) begin
      if (!grant_any && rot[k]) begin
        grant_any = 1'b1;
        grant_off = PW'(k);
      end
    end
  end

  assign grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
  assign grant_idx = (grant_sum >= S_W) ?
                     PW'(grant_sum - S_W) :
                     PW'(grant_sum);

  always_comb begin
    grant_oh = '0;
    for (int k = 0; k < SPRITES; k++) begin
      grant_oh[k] = grant_any &&
                    (grant_idx == PW'(k));
    end
  end

  assign req_ready = arb_en ? grant_oh : '0;
  assign xfer      = |req_ready;
  assign rr_nxt    = (grant_idx == LAST) ?
                     '0 : grant_idx + PW'(1);

  always_ff @(posedge clock_162) begin
    if (rst) begin
      shadow_row  <= '0;
      shadow_col  <= '0;
      sprite_row  <= '0;
      sprite_col  <= '0;
      pending     <= '0;
      rr_ptr      <= '0;
      frame_tick  <= 1'b0;
      missed      <= '0;
      frame_count <= '0;
    end else begin
      frame_tick <= (state == COMMIT);
      if (state == COMMIT) begin
        sprite_row  <= shadow_row;
        sprite_col  <= shadow_col;
        missed      <= ~pending;
        pending     <= '0;
        frame_count <= frame_count + 16'd1;
      end
      if (xfer) begin
        shadow_row[grant_idx] <= req_row[grant_idx];
        shadow_col[grant_idx] <= req_col[grant_idx];
        pending[grant_idx]    <= 1'b1;
        rr_ptr                <= rr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Scoreboard bench for sprite_frame_scheduler with a frame-level reference model.
`timescale 1ns/1ps

module tb_sprite_frame_scheduler;

  localparam int S  = 4;
  localparam int IW = 2;
  localparam int RM = 1249;
  localparam int CM = 2159;

  logic                clock_162 = 1'b0;
  logic                rst;
  logic [10:0]         row;
  logic [11:0]         col;
  logic [S-1:0]        req_valid;
  logic [S-1:0][10:0]  req_row;
  logic [S-1:0][11:0]  req_col;
  logic [S-1:0]        req_ready;
  logic [S-1:0][10:0]  sprite_row;
  logic [S-1:0][11:0]  sprite_col;
  logic                frame_tick;
  logic [S-1:0]        missed;
  logic [15:0]         frame_count;

  always #5 clock_162 = ~clock_162;

  sprite_frame_scheduler #(
    .SPRITES(S),
    .ROW_MAX(RM),
    .COL_MAX(CM)
  ) dut (
    .clock_162  (clock_162),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .req_valid  (req_valid),
    .req_row    (req_row),
    .req_col    (req_col),
    .req_ready  (req_ready),
    .sprite_row (sprite_row),
    .sprite_col (sprite_col),
    .frame_tick (frame_tick),
    .missed     (missed),
    .frame_count(frame_count)
  );

  typedef struct packed {
    logic [S-1:0]       ready;
    logic               tick;
    logic [S-1:0]       miss;
    logic [15:0]        cnt;
    logic [S-1:0][10:0] rows;
    logic [S-1:0][11:0] cols;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   total = 0;
  int   bad   = 0;
  bit   running = 1'b0;
  bit   auto_req = 1'b0;

  // Reference model: what is visible, what is buffered, who is done this frame.
  int       m_lr[S];
  int       m_lc[S];
  int       m_sr[S];
  int       m_sc[S];
  bit       m_pend[S];
  bit [S-1:0] m_miss;
  int       m_rr;
  bit       m_commit;
  bit       m_tick;
  int       m_cnt;

  function automatic void m_reset();
    for (int i = 0; i < S; i++) begin
      m_lr[IW'(i)]   = 0;
      m_lc[IW'(i)]   = 0;
      m_sr[IW'(i)]   = 0;
      m_sc[IW'(i)]   = 0;
      m_pend[IW'(i)] = 1'b0;
    end
    m_miss   = '0;
    m_rr     = 0;
    m_commit = 1'b0;
    m_tick   = 1'b0;
    m_cnt    = 0;
  endfunction

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s act=%0h exp=%0h t=%0t",
                 nm, act, exp, $time);
    end
  endfunction

  initial begin
    forever begin
      @(negedge clock_162);
      if (running) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 64'd0, 64'd1);
        end else begin
          got = sb.pop_front();
          chk("req_ready", 64'(req_ready), 64'(got.ready));
          chk("frame_tick", 64'(frame_tick), 64'(got.tick));
          chk("missed", 64'(missed), 64'(got.miss));
          chk("frame_count", 64'(frame_count), 64'(got.cnt));
          for (int i = 0; i < S; i++) begin
            chk($sformatf("sprite_row%0d", i),
                64'(sprite_row[IW'(i)]), 64'(got.rows[IW'(i)]));
            chk($sformatf("sprite_col%0d", i),
                64'(sprite_col[IW'(i)]), 64'(got.cols[IW'(i)]));
          end
        end
      end
    end
  end

  task automatic cycle(input logic [10:0] r,
                       input logic [11:0] c,
                       input logic rs);
    exp_t e;
    int   g;
    bit   bnd;
    bit   was_commit;
    row = r;
    col = c;
    rst = rs;
    bnd = (int'(r) == RM) && (int'(c) == CM);
    g = -1;
    if (!rs && !m_commit && !bnd) begin
      for (int k = 0; k < S; k++) begin
        int i;
        i = (m_rr + k) % S;
        if (g < 0 && req_valid[IW'(i)] && !m_pend[IW'(i)])
          g = i;
      end
    end
    e.ready = (g >= 0) ? (S'(1) << g) : '0;
    e.tick  = m_tick;
    e.miss  = m_miss;
    e.cnt   = 16'(m_cnt);
    for (int i = 0; i < S; i++) begin
      e.rows[IW'(i)] = 11'(m_lr[IW'(i)]);
      e.cols[IW'(i)] = 12'(m_lc[IW'(i)]);
    end
    sb.push_back(e);
    if (rs) begin
      m_reset();
    end else begin
      was_commit = m_commit;
      m_tick = was_commit;
      if (was_commit) begin
        for (int i = 0; i < S; i++) begin
          m_lr[IW'(i)]   = m_sr[IW'(i)];
          m_lc[IW'(i)]   = m_sc[IW'(i)];
          m_miss[IW'(i)] = !m_pend[IW'(i)];
          m_pend[IW'(i)] = 1'b0;
        end
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (g >= 0) begin
        m_sr[IW'(g)]   = int'(req_row[IW'(g)]);
        m_sc[IW'(g)]   = int'(req_col[IW'(g)]);
        m_pend[IW'(g)] = 1'b1;
        m_rr = (g + 1) % S;
      end
      m_commit = !was_commit && bnd;
    end
    @(posedge clock_162);
    #1;
    if (g >= 0) req_valid[IW'(g)] = 1'b0;
    if (auto_req) begin
      for (int i = 0; i < S; i++) begin
        if (!req_valid[IW'(i)] && $urandom_range(0, 2) == 0) begin
          req_valid[IW'(i)] = 1'b1;
          req_row[IW'(i)]   = 11'($urandom);
          req_col[IW'(i)]   = 12'($urandom);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    logic [10:0] r;
    logic [11:0] c;
    for (int k = 0; k < n; k++) begin
      r = 11'($urandom);
      c = 12'($urandom);
      if (int'(r) == RM && int'(c) == CM) c = 12'd0;
      cycle(r, c, 1'b0);
    end
  endtask

  task automatic eof(input logic rst_in_commit);
    cycle(11'(RM), 12'(CM), 1'b0);
    cycle(11'd0, 12'd0, rst_in_commit);
    cycle(11'd0, 12'd1, 1'b0);
  endtask

  task automatic put(input int i, input int r, input int c);
    req_valid[IW'(i)] = 1'b1;
    req_row[IW'(i)]   = 11'(r);
    req_col[IW'(i)]   = 12'(c);
  endtask

  initial begin
    rst       = 1'b1;
    row       = 11'd500;
    col       = 12'd0;
    req_valid = '1;
    for (int i = 0; i < S; i++) begin
      req_row[IW'(i)] = 11'(10 * i + 1);
      req_col[IW'(i)] = 12'(20 * i + 2);
    end
    m_reset();
    @(posedge clock_162);
    #1;
    running = 1'b1;

    // reset mid-frame with every requester valid
    cycle(11'd500, 12'd10, 1'b1);
    cycle(11'd500, 12'd11, 1'b1);
    // grants 0..3 back to back, then a full commit
    for (int k = 0; k < S; k++) cycle(11'd500, 12'(12 + k), 1'b0);
    idle(2);
    eof(1'b0);

    // single writer at row 500
    put(0, 100, 200);
    cycle(11'd500, 12'd7, 1'b0);
    idle(3);
    eof(1'b0);

    // second write in the same frame stalls to the next frame
    put(2, 10, 20);
    cycle(11'd600, 12'd0, 1'b0);
    put(2, 30, 40);
    idle(4);
    eof(1'b0);
    idle(2);
    eof(1'b0);

    // valid rises exactly in the boundary cycle
    idle(2);
    put(1, 55, 66);
    eof(1'b0);
    idle(2);
    eof(1'b0);

    // reset lands in the commit cycle
    put(0, 300, 400);
    cycle(11'd700, 12'd0, 1'b0);
    idle(2);
    eof(1'b1);
    idle(2);

    // idle frame: no requests at all
    req_valid = '0;
    idle(3);
    eof(1'b0);

    // randomized traffic across many frames
    auto_req = 1'b1;
    for (int f = 0; f < 40; f++) begin
      idle($urandom_range(1, 25));
      eof($urandom_range(0, 15) == 0);
    end
    auto_req  = 1'b0;
    req_valid = '0;
    idle(3);

    running = 1'b0;
    repeat (2) @(negedge clock_162);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
